// File: rtl/cp0_tlb_seq.sv
// CP0-side TLB management sequencer: owns Index/Random/EntryLo0/EntryLo1/PageMask/
// Wired/EntryHi and drives TLBP/TLBR/TLBWI/TLBWR request/acknowledge transactions.

package cp0_tlb_pkg;
    typedef enum logic [2:0] {
        NO_REQ = 3'd0,
        TLBP   = 3'd1,
        TLBR   = 3'd2,
        TLBWI  = 3'd3,
        TLBWR  = 3'd4
    } tlb_req_t;

    typedef struct packed {
        logic [31:0] index;
        logic [31:0] entryhi;
        logic [31:0] entrylo0;
        logic [31:0] entrylo1;
        logic [31:0] pagemask;
    } tlb_t;
endpackage

module cp0_tlb_seq
    import cp0_tlb_pkg::*;
#(
    parameter int TLBEntries = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  tlb_req_t    tlb_op,
    output logic        busy,
    output logic        op_done,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    input  logic        exc_tlb_valid,
    input  logic [31:0] exc_badvaddr,
    output tlb_req_t    tlb_req,
    output tlb_t        tlb_info,
    input  tlb_t        tlb_res,
    input  logic        tlb_ok
);
    localparam int            IW       = $clog2(TLBEntries);
    localparam logic [IW-1:0] RAND_TOP = IW'(TLBEntries - 1);
    localparam logic [31:0]   HI_MASK  = 32'hFFFF_E0FF;

    localparam logic [4:0] REG_INDEX    = 5'd0;
    localparam logic [4:0] REG_RANDOM   = 5'd1;
    localparam logic [4:0] REG_ENTRYLO0 = 5'd2;
    localparam logic [4:0] REG_ENTRYLO1 = 5'd3;
    localparam logic [4:0] REG_WIRED    = 5'd6;
    localparam logic [4:0] REG_ENTRYHI  = 5'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    tlb_req_t      op_q, op_d;
    tlb_req_t      tlb_req_q, tlb_req_d;
    tlb_t          tlb_info_q, tlb_info_d;

    logic          res_p_q, res_p_d;
    logic [IW-1:0] res_idx_q, res_idx_d;
    logic [31:0]   res_hi_q, res_hi_d;
    logic [25:0]   res_lo0_q, res_lo0_d;
    logic [25:0]   res_lo1_q, res_lo1_d;

    logic          p_q, p_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] random_q, random_d;
    logic [IW-1:0] wired_q, wired_d;
    logic [25:0]   lo0_q, lo0_d;
    logic [25:0]   lo1_q, lo1_d;
    logic [31:0]   hi_q, hi_d;

    logic [31:0]   index_rd;
    logic          mtc0_ok;
    logic          wb_tlbp;
    logic          wb_tlbr;

    logic unused_bits;
    assign unused_bits = ^{tlb_res.pagemask, tlb_res.index[30:IW], tlb_res.entrylo0[31:26],
                           tlb_res.entrylo1[31:26], exc_badvaddr[12:0]};

    assign index_rd = {p_q, {(31 - IW){1'b0}}, idx_q};
    assign tlb_req  = tlb_req_q;
    assign tlb_info = tlb_info_q;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path
    // through the case/if tree can leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        tlb_req_d  = tlb_req_q;
        tlb_info_d = tlb_info_q;
        res_p_d    = res_p_q;
        res_idx_d  = res_idx_q;
        res_hi_d   = res_hi_q;
        res_lo0_d  = res_lo0_q;
        res_lo1_d  = res_lo1_q;
        busy       = 1'b0;
        op_done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tlb_op != NO_REQ) begin
                    busy                = 1'b1;
                    op_d                = tlb_op;
                    tlb_req_d           = tlb_op;
                    tlb_info_d.index    = (tlb_op == TLBWR) ? {{(32 - IW){1'b0}}, random_q}
                                                            : index_rd;
                    tlb_info_d.entryhi  = hi_q;
                    tlb_info_d.entrylo0 = {6'b0, lo0_q};
                    tlb_info_d.entrylo1 = {6'b0, lo1_q};
                    tlb_info_d.pagemask = '0;
                    state_d             = ST_REQ;
                end
            end
            ST_REQ: begin
                busy = 1'b1;
                if (tlb_ok) begin
                    res_p_d   = tlb_res.index[31];
                    res_idx_d = tlb_res.index[IW-1:0];
                    res_hi_d  = tlb_res.entryhi & HI_MASK;
                    res_lo0_d = tlb_res.entrylo0[25:0];
                    res_lo1_d = tlb_res.entrylo1[25:0];
                    tlb_req_d = NO_REQ;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                op_done = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Register file updates; later assignments take priority (DONE > exception > MTC0).
    always_comb begin
        mtc0_ok = cp0_we && !busy;
        wb_tlbp = (state_q == ST_DONE) && (op_q == TLBP);
        wb_tlbr = (state_q == ST_DONE) && (op_q == TLBR);

        p_d      = p_q;
        idx_d    = idx_q;
        wired_d  = wired_q;
        lo0_d    = lo0_q;
        lo1_d    = lo1_q;
        hi_d     = hi_q;

        if (mtc0_ok && cp0_waddr == REG_WIRED) begin
            random_d = RAND_TOP;
        end else if (random_q == wired_q || wired_q >= RAND_TOP) begin
            random_d = RAND_TOP;
        end else begin
            random_d = random_q - IW'(1);
        end

        if (mtc0_ok) begin
            case (cp0_waddr)
                REG_INDEX:    idx_d   = cp0_wdata[IW-1:0];
                REG_ENTRYLO0: lo0_d   = cp0_wdata[25:0];
                REG_ENTRYLO1: lo1_d   = cp0_wdata[25:0];
                REG_WIRED:    wired_d = cp0_wdata[IW-1:0];
                REG_ENTRYHI:  hi_d    = cp0_wdata & HI_MASK;
                default: ;
            endcase
        end

        if (exc_tlb_valid) begin
            hi_d[31:13] = exc_badvaddr[31:13];
        end

        if (wb_tlbp) begin
            p_d   = res_p_q;
            idx_d = res_idx_q;
        end
        if (wb_tlbr) begin
            hi_d  = res_hi_q;
            lo0_d = res_lo0_q;
            lo1_d = res_lo1_q;
        end
    end

    always_comb begin
        case (cp0_raddr)
            REG_INDEX:    cp0_rdata = index_rd;
            REG_RANDOM:   cp0_rdata = {{(32 - IW){1'b0}}, random_q};
            REG_ENTRYLO0: cp0_rdata = {6'b0, lo0_q};
            REG_ENTRYLO1: cp0_rdata = {6'b0, lo1_q};
            REG_WIRED:    cp0_rdata = {{(32 - IW){1'b0}}, wired_q};
            REG_ENTRYHI:  cp0_rdata = hi_q;
            default:      cp0_rdata = '0;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= NO_REQ;
            tlb_req_q  <= NO_REQ;
            tlb_info_q <= '0;
            res_p_q    <= 1'b0;
            res_idx_q  <= '0;
            res_hi_q   <= '0;
            res_lo0_q  <= '0;
            res_lo1_q  <= '0;
            p_q        <= 1'b0;
            idx_q      <= '0;
            random_q   <= RAND_TOP;
            wired_q    <= '0;
            lo0_q      <= '0;
            lo1_q      <= '0;
            hi_q       <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            tlb_req_q  <= tlb_req_d;
            tlb_info_q <= tlb_info_d;
            res_p_q    <= res_p_d;
            res_idx_q  <= res_idx_d;
            res_hi_q   <= res_hi_d;
            res_lo0_q  <= res_lo0_d;
            res_lo1_q  <= res_lo1_d;
            p_q        <= p_d;
            idx_q      <= idx_d;
            random_q   <= random_d;
            wired_q    <= wired_d;
            lo0_q      <= lo0_d;
            lo1_q      <= lo1_d;
            hi_q       <= hi_d;
        end
    end

endmodule

// File: tb/tb_cp0_tlb_seq.sv
// Self-checking bench for cp0_tlb_seq: directed vector table, hand-written corner
// sequences and randomized operations against a transaction-level register model.

module tb_cp0_tlb_seq;
    import cp0_tlb_pkg::*;

    localparam int          N       = 32;
    localparam int          IW      = 5;
    localparam logic [31:0] HI_MASK = 32'hFFFF_E0FF;
    localparam logic [31:0] LO_MASK = 32'h03FF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    tlb_req_t    tlb_op;
    logic        busy;
    logic        op_done;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic        exc_tlb_valid;
    logic [31:0] exc_badvaddr;
    tlb_req_t    tlb_req;
    tlb_t        tlb_info;
    tlb_t        tlb_res;
    logic        tlb_ok;

    cp0_tlb_seq #(.TLBEntries(N)) dut (
        .clk(clk), .rst(rst), .tlb_op(tlb_op), .busy(busy), .op_done(op_done),
        .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
        .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
        .exc_tlb_valid(exc_tlb_valid), .exc_badvaddr(exc_badvaddr),
        .tlb_req(tlb_req), .tlb_info(tlb_info), .tlb_res(tlb_res), .tlb_ok(tlb_ok)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Reference model: architectural register contents plus the cycle at which
    // Random last held TLBEntries-1.
    logic          m_p;
    logic [IW-1:0] m_idx;
    logic [IW-1:0] m_wired;
    logic [31:0]   m_lo0, m_lo1, m_hi;
    int            anchor;

    logic [4:0] reg_list [9] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd10, 5'd31};
    logic [4:0] wr_list  [8] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd6, 5'd10, 5'd7};

    typedef struct {
        tlb_req_t    op;
        logic [31:0] pre_index, pre_hi, pre_lo0, pre_lo1;
        logic [31:0] r_index, r_hi, r_lo0, r_lo1;
        logic [31:0] x_index, x_hi, x_lo0, x_lo1;
    } vec_t;

    vec_t vecs [6];

    function automatic int m_random();
        if (int'(m_wired) >= N - 1) return N - 1;
        return N - 1 - ((cyc - anchor) % (N - int'(m_wired)));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd0:    return {m_p, 26'b0, m_idx};
            5'd1:    return 32'(m_random());
            5'd2:    return m_lo0;
            5'd3:    return m_lo1;
            5'd6:    return {27'b0, m_wired};
            5'd10:   return m_hi;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        cp0_raddr = a;
        #1;
        d = cp0_rdata;
    endtask

    task automatic model_reset();
        m_p = 1'b0; m_idx = '0; m_wired = '0;
        m_lo0 = '0; m_lo1 = '0; m_hi = '0;
        anchor = cyc;
    endtask

    task automatic check_regs(input string tag);
        logic [31:0] d;
        foreach (reg_list[i]) begin
            rd(reg_list[i], d);
            check($sformatf("%s reg%0d", tag, reg_list[i]), d, m_read(reg_list[i]));
        end
    endtask

    // MTC0 issued from IDLE with no op pending; the model applies the writable-bit rules.
    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_we = 1'b1; cp0_waddr = a; cp0_wdata = d;
        tick();
        cp0_we = 1'b0;
        case (a)
            5'd0:  m_idx = d[IW-1:0];
            5'd2:  m_lo0 = d & LO_MASK;
            5'd3:  m_lo1 = d & LO_MASK;
            5'd6:  begin m_wired = d[IW-1:0]; anchor = cyc; end
            5'd10: m_hi = d & HI_MASK;
            default: ;
        endcase
    endtask

    // One full operation. lat = REQ cycles before tlb_ok; exc_where 1 = exception in
    // the first REQ cycle, 2 = in DONE; mtc_in_req fires a (dropped) MTC0 during REQ.
    task automatic do_op(input tlb_req_t op, input tlb_t res, input int lat,
                         input int exc_where, input logic [31:0] exc_addr, input bit mtc_in_req);
        logic [31:0] e_index, e_hi, e_lo0, e_lo1;
        e_index = (op == TLBWR) ? 32'(m_random()) : m_read(5'd0);
        e_hi  = m_hi;
        e_lo0 = m_lo0;
        e_lo1 = m_lo1;

        tlb_op = op;
        #1;
        check("accept busy", busy, 1);
        check("accept op_done", op_done, 0);
        check("accept tlb_req", 32'(tlb_req), 32'(NO_REQ));
        tick();
        tlb_op = NO_REQ;

        for (int i = 0; i <= lat; i++) begin
            if (i == 0 && mtc_in_req) begin
                cp0_we    = 1'b1;
                cp0_waddr = wr_list[$urandom_range(0, 7)];
                cp0_wdata = $urandom;
            end
            if (i == 0 && exc_where == 1) begin
                exc_tlb_valid = 1'b1;
                exc_badvaddr  = exc_addr;
                m_hi[31:13]   = exc_addr[31:13];
            end
            if (i == lat) begin
                tlb_ok  = 1'b1;
                tlb_res = res;
            end
            #1;
            check("req tlb_req", 32'(tlb_req), 32'(op));
            check("req info.index", tlb_info.index, e_index);
            check("req info.entryhi", tlb_info.entryhi, e_hi);
            check("req info.entrylo0", tlb_info.entrylo0, e_lo0);
            check("req info.entrylo1", tlb_info.entrylo1, e_lo1);
            check("req info.pagemask", tlb_info.pagemask, 0);
            check("req busy", busy, 1);
            check("req op_done", op_done, 0);
            tick();
            cp0_we        = 1'b0;
            exc_tlb_valid = 1'b0;
            tlb_ok        = 1'b0;
            tlb_res       = {$urandom, $urandom, $urandom, $urandom, $urandom};
        end

        if (exc_where == 2) begin
            exc_tlb_valid = 1'b1;
            exc_badvaddr  = exc_addr;
        end
        #1;
        check("done op_done", op_done, 1);
        check("done busy", busy, 1);
        check("done tlb_req", 32'(tlb_req), 32'(NO_REQ));
        tick();
        exc_tlb_valid = 1'b0;

        if (exc_where == 2) m_hi[31:13] = exc_addr[31:13];
        case (op)
            TLBP: begin
                m_p   = res.index[31];
                m_idx = res.index[IW-1:0];
            end
            TLBR: begin
                m_hi  = res.entryhi & HI_MASK;
                m_lo0 = res.entrylo0 & LO_MASK;
                m_lo1 = res.entrylo1 & LO_MASK;
            end
            default: ;
        endcase
        check("after op_done", op_done, 0);
        check("after busy", busy, 0);
        check_regs("after op");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        tlb_t        res;
        int          waited;

        vecs[0] = '{TLBWI, 32'd3, 32'h0040_2005, 32'h0000_1016, 32'h0000_1056,
                    32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                    32'd3, 32'h0040_2005, 32'h0000_1016, 32'h0000_1056};
        vecs[1] = '{TLBR, 32'd3, 32'h0040_2005, 32'h0000_1016, 32'h0000_1056,
                    32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0AB1_2345,
                    32'd3, 32'hFFFF_E0FF, 32'h03FF_FFFF, 32'h02B1_2345};
        vecs[2] = '{TLBP, 32'd0, 32'h0040_2005, 32'h0000_1016, 32'h0000_1056,
                    32'h8000_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                    32'h8000_0000, 32'h0040_2005, 32'h0000_1016, 32'h0000_1056};
        vecs[3] = '{TLBP, 32'd7, 32'h0040_2005, 32'h0000_1016, 32'h0000_1056,
                    32'd5, 32'h0, 32'h0, 32'h0,
                    32'd5, 32'h0040_2005, 32'h0000_1016, 32'h0000_1056};
        vecs[4] = '{TLBP, 32'd9, 32'h0040_2005, 32'h0000_1016, 32'h0000_1056,
                    32'h7FFF_FFE3, 32'h0, 32'h0, 32'h0,
                    32'd3, 32'h0040_2005, 32'h0000_1016, 32'h0000_1056};
        vecs[5] = '{TLBWI, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFC00_0000,
                    32'h0, 32'h0, 32'h0, 32'h0,
                    32'h0000_001F, 32'hFFFF_E0FF, 32'h03FF_FFFF, 32'h0};

        rst = 1'b1; tlb_op = NO_REQ; cp0_we = 1'b0; cp0_waddr = '0; cp0_wdata = '0;
        cp0_raddr = '0; exc_tlb_valid = 1'b0; exc_badvaddr = '0; tlb_res = '0; tlb_ok = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        model_reset();

        // Reset state
        check("reset busy", busy, 0);
        check("reset op_done", op_done, 0);
        check("reset tlb_req", 32'(tlb_req), 32'(NO_REQ));
        check("reset info.index", tlb_info.index, 0);
        check("reset info.entryhi", tlb_info.entryhi, 0);
        rd(5'd0, d);  check("reset index", d, 0);
        rd(5'd2, d);  check("reset entrylo0", d, 0);
        rd(5'd6, d);  check("reset wired", d, 0);
        rd(5'd10, d); check("reset entryhi", d, 0);

        // Random counts 31..0 then reloads to 31
        for (int i = 0; i < 33; i++) begin
            rd(5'd1, d);
            check($sformatf("random step %0d", i), d, (i < 32) ? 32'(31 - i) : 32'd31);
            tick();
        end
        mtc0(5'd6, 32'd8);
        for (int i = 0; i < 26; i++) begin
            rd(5'd1, d);
            check($sformatf("random wired8 step %0d", i), d, 32'(31 - (i % 24)));
            tick();
        end
        mtc0(5'd6, 32'd0);

        // Directed vector table
        foreach (vecs[v]) begin
            mtc0(5'd0, vecs[v].pre_index);
            mtc0(5'd10, vecs[v].pre_hi);
            mtc0(5'd2, vecs[v].pre_lo0);
            mtc0(5'd3, vecs[v].pre_lo1);
            res = '{index: vecs[v].r_index, entryhi: vecs[v].r_hi, entrylo0: vecs[v].r_lo0,
                    entrylo1: vecs[v].r_lo1, pagemask: 32'h0};
            do_op(vecs[v].op, res, 1, 0, 32'h0, 1'b0);
            rd(5'd0, d);  check($sformatf("vec%0d index", v), d, vecs[v].x_index);
            rd(5'd10, d); check($sformatf("vec%0d entryhi", v), d, vecs[v].x_hi);
            rd(5'd2, d);  check($sformatf("vec%0d entrylo0", v), d, vecs[v].x_lo0);
            rd(5'd3, d);  check($sformatf("vec%0d entrylo1", v), d, vecs[v].x_lo1);
        end

        // TLBWR latches Random = 17 at acceptance
        waited = 0;
        while (m_random() != 17 && waited < 64) begin
            tick();
            waited++;
        end
        check("tlbwr reached random 17", 32'(waited < 64), 1);
        rd(5'd1, d);
        check("tlbwr random before", d, 17);
        do_op(TLBWR, '{default: 32'h5A5A_5A5A}, 3, 0, 32'h0, 1'b0);

        // Exception and MTC0 EntryHi in the same idle cycle
        cp0_we = 1'b1; cp0_waddr = 5'd10; cp0_wdata = 32'hAAAA_AAAA;
        exc_tlb_valid = 1'b1; exc_badvaddr = 32'h1234_5678;
        tick();
        cp0_we = 1'b0; exc_tlb_valid = 1'b0;
        rd(5'd10, d);
        check("exc+mtc0 entryhi", d, 32'h1234_40AA);
        exc_tlb_valid = 1'b1; exc_badvaddr = 32'hFFFF_FFFF;
        tick();
        exc_tlb_valid = 1'b0;
        rd(5'd10, d);
        check("exc only entryhi", d, 32'hFFFF_E0AA);
        m_hi = 32'hFFFF_E0AA;

        // tlb_ok while idle is ignored
        tlb_ok = 1'b1; tlb_res = '{default: 32'hFFFF_FFFF};
        tick();
        tlb_ok = 1'b0;
        check("idle ok op_done", op_done, 0);
        check("idle ok busy", busy, 0);
        check("idle ok tlb_req", 32'(tlb_req), 32'(NO_REQ));
        tick();
        check_regs("idle ok");

        // Randomized operations against the model
        for (int it = 0; it < 60; it++) begin
            tlb_req_t op;
            int       nw;
            nw = $urandom_range(0, 2);
            for (int w = 0; w < nw; w++) begin
                if ($urandom_range(0, 7) == 0) mtc0(5'd6, 32'd31);
                else mtc0(wr_list[$urandom_range(0, 7)], $urandom);
            end
            op  = tlb_req_t'($urandom_range(1, 4));
            res = {$urandom, $urandom, $urandom, $urandom, $urandom};
            if (op == TLBP && res.index[31]) res.index[IW-1:0] = m_idx;
            do_op(op, res, $urandom_range(0, 3), $urandom_range(0, 2), $urandom,
                  1'($urandom_range(0, 1)));
            for (int k = $urandom_range(0, 2); k > 0; k--) tick();
            check_regs("random idle");
        end

        // Reset during REQ: no writeback, bus returns to NO_REQ
        mtc0(5'd10, 32'h0040_2005);
        tlb_op = TLBR;
        tick();
        tlb_op = NO_REQ;
        rst = 1'b1; tlb_ok = 1'b1; tlb_res = '{default: 32'hFFFF_FFFF};
        #1;
        check("rst-in-req tlb_req before", 32'(tlb_req), 32'(TLBR));
        tick();
        rst = 1'b0;
        model_reset();
        check("rst-in-req tlb_req", 32'(tlb_req), 32'(NO_REQ));
        check("rst-in-req busy", busy, 0);
        check("rst-in-req op_done", op_done, 0);
        tick();
        tlb_ok = 1'b0;
        check("rst-in-req no done", op_done, 0);
        rd(5'd10, d); check("rst-in-req entryhi", d, 0);
        rd(5'd2, d);  check("rst-in-req entrylo0", d, 0);
        rd(5'd3, d);  check("rst-in-req entrylo1", d, 0);
        check_regs("post reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
